timer_dev: RTL and testbench
============================

# timer_dev

Memory-mapped countdown timer on the processor bus, downstream of the data-memory stage via the system bridge. The bridge forwards the stage's word address, write data, write enable and byte enables, with the write enable already qualified by address decode. The timer returns read data combinationally and raises an interrupt line to the CP0/exception logic. Two modes: one-shot (interrupt held until software acknowledges) and auto-reload (periodic one-cycle interrupt pulse).

## Interface
- No parameters; data width is the shared 32-bit word.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- addr  in  2  register select (bus address bits [3:2]): 0 CTRL, 1 PRESET, 2 COUNT, 3 unmapped
- we  in  1  write strobe, already qualified by bridge decode
- be  in  4  byte enables; bit i enables byte lane i of wd
- wd  in  32  write data, already lane-aligned by the data-memory stage
- rd  out  32  read data of the selected register, combinational
- irq  out  1  interrupt request

## Operation
- CTRL: bit0 EN, bits[2:1] MODE (0 one-shot, 1 auto-reload; 2 and 3 behave as 0), bit3 IM (irq mask, 1 = enabled). Bits[31:4] read 0; writes to them are ignored.
- PRESET: 32-bit reload value, fully read/write.
- COUNT: read-only current value; writes are ignored. addr 3 reads 0; writes to it are ignored.
- Writes merge per byte: each lane with be[i]=1 takes wd lane i, and the other lanes keep their value. be=0000 with we=1 changes nothing.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT:
    - EN=0 -> IDLE, COUNT holds.
    - Else COUNT>1 -> decrement.
    - Else COUNT<=0 -> INT.
  - INT, mode 0: EN cleared on entry. Stays in INT until any CTRL write, then -> IDLE. The following cycle enters LOAD if that write set EN.
  - INT, mode 1: single cycle -> LOAD. EN unchanged.
- irq = IM & (state==INT). Mode 0 gives a level until acknowledged; mode 1 gives a 1-cycle pulse.
- PRESET=0 behaves as PRESET=1 (LOAD, one CNT cycle, INT).
- Software write vs FSM in the same cycle:
  - A CTRL write wins over the FSM clearing EN on INT entry.
  - A PRESET write during CNT affects only the next LOAD.
  - A PRESET write in the LOAD cycle: COUNT takes the old PRESET value.
- Clearing EN mid-count freezes COUNT. Re-enabling reloads from PRESET, with no resume.

## Timing
- After reset: CTRL=0, PRESET=0, COUNT=0, state IDLE, irq=0. rd reflects reset values immediately.
- Register writes take effect at the rising edge ending the we cycle.
- rd has zero latency: it follows addr and register contents in the same cycle.
- Latency from a CTRL write setting EN (edge E) in IDLE:
  - LOAD after E+1.
  - COUNT=PRESET=N after E+2.
  - INT/irq after E+N+2.
- Auto-reload period with PRESET=N≥1: N+2 cycles between irq pulses.
- Reset asserted in any state returns to the reset values at that edge; in-flight writes are discarded.

## Structure
- Shared header (the existing macro header): `Word range, register offsets, CTRL bit positions, MODE values, FSM state encoding.
- One sub-module, be_merge (old word, new word, be -> merged word), instantiated for CTRL and PRESET.
- The bridge module decodes the timer address window.

## Test plan
- Reset: drive reset 1 cycle. Read all three registers -> 0. irq=0.
- Byte-lane write: PRESET=0x11223344, then write wd=0xAABBCCDD with be=0110. Read PRESET -> 0x11BBCC44.
- One-shot:
  - Setup: PRESET=5, then CTRL=0x9 (EN, mode 0, IM) at edge E.
  - Required: irq rises after E+7 and stays high; CTRL reads 0x8.
  - Acknowledge: writing CTRL=0x8 drops irq at the next edge, state IDLE.
- Auto-reload: PRESET=3, CTRL=0xB. irq pulses exactly 1 cycle wide, every 5 cycles, for ≥4 periods. COUNT sequence 3,2,1,0.
- Mask and freeze:
  - IM=0 one-shot with PRESET=2: irq never asserts, yet COUNT reaches 0 and EN clears.
  - Separately, clear EN mid-count at COUNT=7: COUNT holds 7.
  - Re-enable: COUNT reloads PRESET.
- Edge cases:
  - A write to COUNT is ignored.
  - A write to addr 3 is ignored, and addr 3 reads 0.
  - PRESET=0 with EN: irq after E+3.
  - Reset asserted mid-CNT: all registers 0 at the next edge.

Source files
------------

// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped countdown timer: word width,
// register offsets, CTRL field positions, mode codes and FSM encoding.
package timer_dev_pkg;

  localparam int wordW = 32;

  localparam logic [1:0] addrCtrl   = 2'd0;
  localparam logic [1:0] addrPreset = 2'd1;
  localparam logic [1:0] addrCount  = 2'd2;
  localparam logic [1:0] addrNone   = 2'd3;

  localparam int ctrlEnBit  = 0;
  localparam int ctrlModeLo = 1;
  localparam int ctrlModeHi = 2;
  localparam int ctrlImBit  = 3;

  // Only the low nibble of CTRL is implemented; everything above reads 0.
  localparam logic [wordW-1:0] ctrlWrMask = 32'h0000_000F;

  localparam logic [1:0] modeOneShot = 2'd0;
  localparam logic [1:0] modeReload  = 2'd1;

  typedef enum logic [1:0] {
    stIdle = 2'd0,
    stLoad = 2'd1,
    stCnt  = 2'd2,
    stInt  = 2'd3
  } timerState_t;

endpackage

// File: rtl/timer_dev_be_merge.sv
// Byte-lane write merge: lanes with be set take the new word, the rest keep
// the old word.
module timer_dev_be_merge
  import timer_dev_pkg::*;
(
  input  logic [wordW-1:0] oldWord,
  input  logic [wordW-1:0] newWord,
  input  logic [3:0]       be,
  output logic [wordW-1:0] mergedWord
);

  // Per-lane select between old and new contents.
  always_comb begin
    mergedWord = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mergedWord[8*i +: 8] = newWord[8*i +: 8];
    end
  end

endmodule

// File: rtl/timer_dev.sv
// Countdown timer with one-shot (acknowledged level irq) and auto-reload
// (periodic one-cycle irq pulse) modes, read combinationally over the bus.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | stopped; waits for EN
// LOAD  | COUNT takes PRESET (old value if PRESET is written this cycle)
// CNT   | counting down; EN=0 freezes COUNT and returns to IDLE
// INT   | terminal count; one-shot waits for a CTRL write, reload restarts
module timer_dev
  import timer_dev_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [wordW-1:0]  wd,
  output logic [wordW-1:0]  rd,
  output logic              irq
);

  logic [wordW-1:0] ctrlReg;
  logic [wordW-1:0] presetReg;
  logic [wordW-1:0] countReg;
  logic [wordW-1:0] countNext;
  logic [wordW-1:0] ctrlMerged;
  logic [wordW-1:0] presetMerged;
  timerState_t      state;
  timerState_t      stateNext;
  logic             clrEn;
  logic             ctrlWe;
  logic             presetWe;
  logic             en;
  logic             im;
  logic [1:0]       mode;

  assign ctrlWe   = we && (addr == addrCtrl);
  assign presetWe = we && (addr == addrPreset);
  assign en       = ctrlReg[ctrlEnBit];
  assign im       = ctrlReg[ctrlImBit];
  assign mode     = ctrlReg[ctrlModeHi:ctrlModeLo];

  timer_dev_be_merge u_ctrlMerge (
    .oldWord    (ctrlReg),
    .newWord    (wd),
    .be         (be),
    .mergedWord (ctrlMerged)
  );

  timer_dev_be_merge u_presetMerge (
    .oldWord    (presetReg),
    .newWord    (wd),
    .be         (be),
    .mergedWord (presetMerged)
  );

  // Next-state, counter and EN-clear decisions for the countdown FSM.
  always_comb begin
    stateNext = state;
    countNext = countReg;
    clrEn     = 1'b0;
    unique case (state)
      stIdle: begin
        if (en) stateNext = stLoad;
      end
      stLoad: begin
        countNext = presetReg;
        stateNext = stCnt;
      end
      stCnt: begin
        if (!en) begin
          stateNext = stIdle;
        end else if (countReg > 32'd1) begin
          countNext = countReg - 32'd1;
        end else begin
          // A count of 0 or 1 both terminate here, so PRESET=0 acts as 1.
          countNext = '0;
          stateNext = stInt;
          clrEn     = (mode != modeReload);
        end
      end
      stInt: begin
        if (mode == modeReload) stateNext = stLoad;
        else if (ctrlWe)        stateNext = stIdle;
      end
    endcase
  end

  // FSM state and COUNT registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= stIdle;
      countReg <= '0;
    end else begin
      state    <= stateNext;
      countReg <= countNext;
    end
  end

  // CTRL register; a software write takes priority over the one-shot EN clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlReg <= '0;
    end else if (ctrlWe) begin
      ctrlReg <= ctrlMerged & ctrlWrMask;
    end else if (clrEn) begin
      ctrlReg[ctrlEnBit] <= 1'b0;
    end
  end

  // PRESET register, byte-merged writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      presetReg <= '0;
    end else if (presetWe) begin
      presetReg <= presetMerged;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    rd = '0;
    unique case (addr)
      addrCtrl:   rd = ctrlReg;
      addrPreset: rd = presetReg;
      addrCount:  rd = countReg;
      addrNone:   rd = '0;
    endcase
  end

  assign irq = im && (state == stInt);

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: register-access vector table followed by
// hand-timed sequences for one-shot, auto-reload, masking, freeze and reset.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int nChecks = 0;
  int nFail   = 0;

  localparam logic [1:0] aCtrl   = 2'd0;
  localparam logic [1:0] aPreset = 2'd1;
  localparam logic [1:0] aCount  = 2'd2;
  localparam logic [1:0] aNone   = 2'd3;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [1:0]  rdAddr;
    logic [31:0] expRd;
    string       name;
  } vec_t;

  vec_t vecs[9];

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .be    (be),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus write; returns 1ns after the edge that commits it.
  task automatic busWrite(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    we   = 1'b1;
    be   = b;
    wd   = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    be = 4'h0;
  endtask

  task automatic readCheck(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rd, exp);
  endtask

  initial begin
    reset = 1'b1;
    addr  = aCtrl;
    we    = 1'b0;
    be    = 4'h0;
    wd    = '0;

    vecs[0] = '{1'b1, aPreset, 4'hF, 32'h11223344, aPreset, 32'h11223344, "preset_full"};
    vecs[1] = '{1'b1, aPreset, 4'h6, 32'hAABBCCDD, aPreset, 32'h11BBCC44, "preset_lanes"};
    vecs[2] = '{1'b1, aPreset, 4'h0, 32'hFFFFFFFF, aPreset, 32'h11BBCC44, "preset_be0"};
    vecs[3] = '{1'b1, aCtrl,   4'hF, 32'hFFFFFFF6, aCtrl,   32'h00000006, "ctrl_upper_ignored"};
    vecs[4] = '{1'b1, aCtrl,   4'hE, 32'h0000000E, aCtrl,   32'h00000006, "ctrl_lane0_kept"};
    vecs[5] = '{1'b1, aCount,  4'hF, 32'h12345678, aCount,  32'h00000000, "count_write_ignored"};
    vecs[6] = '{1'b1, aNone,   4'hF, 32'hDEADBEEF, aNone,   32'h00000000, "addr3_reads0"};
    vecs[7] = '{1'b1, aCtrl,   4'h1, 32'h00000000, aCtrl,   32'h00000000, "ctrl_clear"};
    vecs[8] = '{1'b0, aPreset, 4'hF, 32'h00000000, aPreset, 32'h11BBCC44, "preset_kept"};

    // Reset and reset values.
    tick(2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    readCheck("reset_ctrl",   aCtrl,   32'h0);
    readCheck("reset_preset", aPreset, 32'h0);
    readCheck("reset_count",  aCount,  32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);

    // Register access table (EN stays 0 throughout).
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      addr = vecs[i].addr;
      we   = vecs[i].we;
      be   = vecs[i].be;
      wd   = vecs[i].wd;
      @(posedge clk);
      #1;
      we = 1'b0;
      be = 4'h0;
      readCheck(vecs[i].name, vecs[i].rdAddr, vecs[i].expRd);
    end

    // One-shot: PRESET=5, irq rises after E+7 and holds.
    busWrite(aPreset, 4'hF, 32'd5);
    busWrite(aCtrl,   4'hF, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check($sformatf("oneshot_irq_E+%0d", k), {31'd0, irq}, (k >= 7) ? 32'd1 : 32'd0);
    end
    tick(3);
    check("oneshot_irq_held", {31'd0, irq}, 32'd1);
    readCheck("oneshot_ctrl_en_cleared", aCtrl, 32'h8);
    readCheck("oneshot_count0", aCount, 32'h0);
    busWrite(aCtrl, 4'hF, 32'h8);
    check("oneshot_ack_irq", {31'd0, irq}, 32'd0);
    tick(3);
    check("oneshot_idle_irq", {31'd0, irq}, 32'd0);
    readCheck("oneshot_idle_count", aCount, 32'h0);

    // Auto-reload: PRESET=3, period 5, one-cycle pulses, COUNT 3,2,1,0.
    busWrite(aPreset, 4'hF, 32'd3);
    busWrite(aCtrl,   4'hF, 32'hB);
    addr = aCount;
    for (int k = 1; k <= 25; k++) begin
      logic [31:0] expCount;
      tick(1);
      case (k % 5)
        1:       expCount = 32'd0;
        2:       expCount = 32'd3;
        3:       expCount = 32'd2;
        4:       expCount = 32'd1;
        default: expCount = 32'd0;
      endcase
      check($sformatf("reload_irq_E+%0d", k), {31'd0, irq}, (k % 5 == 0) ? 32'd1 : 32'd0);
      check($sformatf("reload_count_E+%0d", k), rd, expCount);
    end
    busWrite(aCtrl, 4'hF, 32'h0);
    tick(3);
    check("reload_stopped_irq", {31'd0, irq}, 32'd0);

    // Masked one-shot: no irq, COUNT reaches 0, EN clears.
    busWrite(aPreset, 4'hF, 32'd2);
    busWrite(aCtrl,   4'hF, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check($sformatf("masked_irq_E+%0d", k), {31'd0, irq}, 32'd0);
    end
    readCheck("masked_count0", aCount, 32'h0);
    readCheck("masked_en_cleared", aCtrl, 32'h0);
    busWrite(aCtrl, 4'hF, 32'h0);

    // Freeze at 7 and reload on re-enable.
    busWrite(aPreset, 4'hF, 32'd10);
    busWrite(aCtrl,   4'hF, 32'h1);
    tick(4);
    readCheck("freeze_count_E+4", aCount, 32'd8);
    busWrite(aCtrl, 4'hF, 32'h0);
    readCheck("freeze_count_E+5", aCount, 32'd7);
    tick(4);
    readCheck("freeze_count_held", aCount, 32'd7);
    busWrite(aCtrl, 4'hF, 32'h1);
    readCheck("reenable_F+0", aCount, 32'd7);
    tick(1);
    readCheck("reenable_F+1", aCount, 32'd7);
    tick(1);
    readCheck("reenable_reload", aCount, 32'd10);

    // Reset mid-count with a write in flight.
    tick(2);
    readCheck("midcnt_count", aCount, 32'd8);
    @(negedge clk);
    reset = 1'b1;
    addr  = aPreset;
    we    = 1'b1;
    be    = 4'hF;
    wd    = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    reset = 1'b0;
    we    = 1'b0;
    be    = 4'h0;
    readCheck("rst_ctrl",   aCtrl,   32'h0);
    readCheck("rst_preset", aPreset, 32'h0);
    readCheck("rst_count",  aCount,  32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // PRESET=0 with EN: irq after E+3.
    busWrite(aCtrl, 4'hF, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      check($sformatf("preset0_irq_E+%0d", k), {31'd0, irq}, (k >= 3) ? 32'd1 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
